// File: rtl/midi_note_tx.sv
// MIDI note-event transmitter: captures one channel-voice event and shifts its three bytes
// out as 8N1 MIDI UART (LSB first, idle high).
module midi_note_tx #(
   parameter int unsigned CLKS_PER_BIT = 1600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic        ev_note_on,
   input  logic [3:0]  ev_channel,
   input  logic [7:0]  ev_pitch,
   input  logic [7:0]  ev_velocity,
   output logic [31:0] msg_word,
   output logic        tx_serial,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

   state_e      state_q, state_d;
   logic [1:0]  byte_q, byte_d;
   logic [2:0]  bit_q, bit_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] msg_q, msg_d;
   logic        tx_q, tx_d;
   logic        done_q, done_d;
   logic        bit_end;
   logic [7:0]  cur_byte;
   logic        unused_msb;

   assign bit_end    = (cnt_q == LastCnt);
   // Data-byte MSBs are forced to zero on capture, so the inputs' bit 7 is never used.
   assign unused_msb = ev_pitch[7] ^ ev_velocity[7];

   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      bit_d    = bit_q;
      cnt_d    = cnt_q;
      msg_d    = msg_q;
      done_d   = 1'b0;
      cur_byte = 8'h00;
      tx_d     = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (ev_valid) begin
               state_d = StStart;
               byte_d  = 2'd0;
               cnt_d   = 16'd0;
               msg_d   = {8'h00, 3'b100, ev_note_on, ev_channel,
                          1'b0, ev_pitch[6:0], 1'b0, ev_velocity[6:0]};
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = 3'd0;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = 16'd0;
               if (bit_q == 3'd7) state_d = StStop;
               else bit_d = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d = 16'd0;
               if (byte_q == 2'd2) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  byte_d  = byte_q + 2'd1;
                  state_d = StStart;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // The line level is computed from the next state so tx_serial comes straight from a flop.
      unique case (byte_d)
         2'd0:    cur_byte = msg_d[23:16];
         2'd1:    cur_byte = msg_d[15:8];
         default: cur_byte = msg_d[7:0];
      endcase
      if (state_d == StStart)     tx_d = 1'b0;
      else if (state_d == StData) tx_d = cur_byte[bit_d];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         byte_q  <= 2'd0;
         bit_q   <= 3'd0;
         cnt_q   <= 16'd0;
         msg_q   <= 32'h0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign ev_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign tx_serial = tx_q;
   assign msg_word  = msg_q;

endmodule

// File: tb/tb_midi_note_tx.sv
// Randomised bench for midi_note_tx: a frame-level reference model predicts the line level,
// busy, ready, done and msg_word for every clock interval.
module tb_midi_note_tx;

   localparam int unsigned C    = 4;
   localparam int unsigned LINE = 30 * C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ev_valid = 1'b0;
   logic        ev_note_on = 1'b0;
   logic [3:0]  ev_channel = 4'h0;
   logic [7:0]  ev_pitch = 8'h00;
   logic [7:0]  ev_velocity = 8'h00;
   logic        ev_ready;
   logic [31:0] msg_word;
   logic        tx_serial;
   logic        busy;
   logic        done;

   midi_note_tx #(.CLKS_PER_BIT(C)) dut (
      .clk         (clk),
      .rst         (rst),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_note_on  (ev_note_on),
      .ev_channel  (ev_channel),
      .ev_pitch    (ev_pitch),
      .ev_velocity (ev_velocity),
      .msg_word    (msg_word),
      .tx_serial   (tx_serial),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one accepted event owns the line for LINE intervals starting at m_start.
   int unsigned cyc = 0;
   int unsigned m_start = 0;
   int unsigned m_accepts = 0;
   logic        m_active = 1'b0;
   logic [29:0] m_frame = '0;
   logic [31:0] m_msg = 32'h0;
   int          n_done = 0;

   function automatic logic [31:0] pack_msg(input logic on, input logic [3:0] ch,
                                            input logic [7:0] p, input logic [7:0] v);
      return {8'h00, 4'h8 | {3'b000, on}, ch, 8'(p % 128), 8'(v % 128)};
   endfunction

   function automatic logic [29:0] make_frame(input logic [31:0] w);
      logic [29:0] f;
      logic [7:0]  b;
      f = '0;
      for (int k = 0; k < 3; k++) begin
         b = w[23 - 8*k -: 8];
         f[10*k] = 1'b0;
         for (int j = 0; j < 8; j++) f[10*k + 1 + j] = b[j];
         f[10*k + 9] = 1'b1;
      end
      return f;
   endfunction

   function automatic logic busy_now();
      return m_active && ((cyc - m_start) < LINE);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_msg    <= 32'h0;
      end else begin
         cyc <= cyc + 1;
         if (!busy_now() && ev_valid) begin
            m_active  <= 1'b1;
            m_start   <= cyc + 1;
            m_msg     <= pack_msg(ev_note_on, ev_channel, ev_pitch, ev_velocity);
            m_frame   <= make_frame(pack_msg(ev_note_on, ev_channel, ev_pitch, ev_velocity));
            m_accepts <= m_accepts + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         int unsigned off;
         logic b_e;
         off = cyc - m_start;
         b_e = busy_now();
         check_eq("tx_serial", tx_serial, b_e ? m_frame[off / C] : 1'b1);
         check_eq("busy", busy, b_e);
         check_eq("ev_ready", ev_ready, !b_e);
         check_eq("done", done, m_active && off == LINE);
         check_eq("msg_word", msg_word, m_msg);
         if (done) n_done++;
      end
   end

   // Called at a falling edge; leaves ev_valid high so the caller decides when to drop it.
   task automatic send(input logic on, input logic [3:0] ch, input logic [7:0] p,
                       input logic [7:0] v);
      int unsigned a0;
      ev_note_on  = on;
      ev_channel  = ch;
      ev_pitch    = p;
      ev_velocity = v;
      ev_valid    = 1'b1;
      a0 = m_accepts;
      for (int i = 0; i < 2 * LINE && m_accepts == a0; i++) @(negedge clk);
      check_eq("accept_timeout", m_accepts - a0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2 * LINE && busy_now(); i++) @(negedge clk);
      check_eq("idle_timeout", busy_now(), 1'b0);
      @(negedge clk);
   endtask

   task automatic done_latency(input string tag);
      int k;
      k = 0;
      while (!done && k < 2 * LINE) begin
         @(negedge clk);
         k++;
      end
      check_eq(tag, k, LINE);
   endtask

   initial begin
      int d0;
      #2 rst = 1'b1;
      #1;
      check_eq("rst_tx", tx_serial, 1'b1);
      check_eq("rst_ready", ev_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_msg", msg_word, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Note On ch0
      send(1'b1, 4'd0, 8'h3C, 8'h64);
      ev_valid = 1'b0;
      check_eq("msg_note_on", msg_word, 32'h00903C64);
      done_latency("done_latency_on");
      wait_idle();

      // Note Off ch5 with data MSBs set
      send(1'b0, 4'd5, 8'hAA, 8'hFF);
      ev_valid = 1'b0;
      check_eq("msg_note_off", msg_word, 32'h00852A7F);
      done_latency("done_latency_off");
      wait_idle();

      // Note On with velocity 0 stays Note On
      send(1'b1, 4'd15, 8'h40, 8'h00);
      ev_valid = 1'b0;
      check_eq("msg_vel0", msg_word, 32'h009F4000);
      wait_idle();

      // Back-to-back with ev_valid held high throughout
      d0 = n_done;
      for (int e = 0; e < 4; e++)
         send(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom));
      ev_valid = 1'b0;
      wait_idle();
      check_eq("b2b_done_count", n_done - d0, 4);

      // Randomised events with random gaps
      d0 = n_done;
      for (int e = 0; e < 20; e++) begin
         send(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 2) != 0) begin
            ev_valid = 1'b0;
            repeat ($urandom_range(0, 6)) @(negedge clk);
         end
      end
      ev_valid = 1'b0;
      wait_idle();
      check_eq("rand_done_count", n_done - d0, 20);

      // Reset during bit 3 of the pitch byte
      send(1'b1, 4'd3, 8'h55, 8'h22);
      ev_valid = 1'b0;
      for (int i = 0; i < 2 * LINE && (cyc - m_start) < 14 * C + 1; i++) @(negedge clk);
      d0 = n_done;
      #1 rst = 1'b1;
      #1;
      check_eq("mid_rst_tx", tx_serial, 1'b1);
      check_eq("mid_rst_ready", ev_ready, 1'b1);
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_done", done, 1'b0);
      check_eq("mid_rst_msg", msg_word, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (LINE) @(negedge clk);
      check_eq("no_done_after_rst", n_done - d0, 0);

      // Fresh event after reset
      send(1'b1, 4'd1, 8'h2A, 8'h7F);
      ev_valid = 1'b0;
      check_eq("msg_after_rst", msg_word, 32'h00912A7F);
      done_latency("done_latency_after_rst");
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
